// File: rtl/bla_sub_pipe.sv
// bla_sub_pipe: pipelined a - b - b_in built from 4-bit
// borrow-lookahead slices, one slice per pipeline stage.
module bla_sub_pipe #(
    parameter int WIDTH = 16,
    localparam int STAGES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    typedef struct packed {
        logic       bm;
        logic       bo;
        logic [3:0] d;
    } slice_t;

    function automatic slice_t bl_slice(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       bi
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] br;
        slice_t     r;
        g     = ~x & y;
        p     = ~(x ^ y);
        br[0] = bi;
        br[1] = g[0] | (p[0] & bi);
        br[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & bi);
        br[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0])
              | (&p[2:0] & bi);
        br[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1])
              | (&p[3:1] & g[0]) | (&p[3:0] & bi);
        r.d   = x ^ y ^ br[3:0];
        r.bo  = br[4];
        r.bm  = br[3];
        return r;
    endfunction

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] bo_q, bo_d;
    logic              msb_q, msb_d;
    logic [WIDTH-1:0]  dif_q [STAGES];
    logic [WIDTH-1:0]  dif_d [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    slice_t            sl    [STAGES];
    logic              stall;

    assign sl[0] = bl_slice(a[3:0], b[3:0], b_in);

    // Slice k borrows from the stage k-1 register, not from slice k-1.
    for (genvar k = 1; k < STAGES; k++) begin : g_sl
        assign sl[k] = bl_slice(opa_q[k-1][4*k +: 4],
                                opb_q[k-1][4*k +: 4],
                                bo_q[k-1]);
    end

    assign out_valid = vld_q[STAGES-1];
    assign diff      = dif_q[STAGES-1];
    assign b_out     = bo_q[STAGES-1];
    assign ovf       = msb_q ^ bo_q[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    always_comb begin
        vld_d = vld_q;
        bo_d  = bo_q;
        msb_d = msb_q;
        for (int k = 0; k < STAGES; k++) begin
            dif_d[k] = dif_q[k];
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
        end
        if (!stall) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                dif_d[0]      = '0;
                dif_d[0][3:0] = sl[0].d;
                opa_d[0]      = a;
                opb_d[0]      = b;
                bo_d[0]       = sl[0].bo;
                if (STAGES == 1) msb_d = sl[0].bm;
            end
            // Data only moves with a valid token so outputs hold across bubbles.
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    dif_d[k]            = dif_q[k-1];
                    dif_d[k][4*k +: 4]  = sl[k].d;
                    opa_d[k]            = opa_q[k-1];
                    opb_d[k]            = opb_q[k-1];
                    bo_d[k]             = sl[k].bo;
                    if (k == STAGES - 1) msb_d = sl[k].bm;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            bo_q  <= '0;
            msb_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                dif_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            bo_q  <= bo_d;
            msb_q <= msb_d;
            for (int k = 0; k < STAGES; k++) begin
                dif_q[k] <= dif_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
        end
    end

endmodule

// File: doc/bla_sub_pipe.md
Name: bla_sub_pipe

Overview:
- Pipelined WIDTH-bit subtractor computing diff = a - b - b_in. It is the inverse datapath of the team's 4-bit carry-lookahead adder.
- Built from 4-bit borrow-lookahead slices, one slice per pipeline stage.
- Uses a valid/ready handshake on both sides.
- Sits in the arithmetic datapath beside the adder, feeding downstream compare and decrement logic.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- STAGES, WIDTH/4, number of pipeline stages (derived; not for override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a, b, b_in are valid this cycle.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  minuend, unsigned or two's complement.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow-in.
- out_valid  output  1  diff, b_out, ovf are valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a - b - b_in, modulo 2^WIDTH.
- b_out  output  1  borrow out of the MSB; 1 iff unsigned a < b + b_in.
- ovf  output  1  signed overflow = (borrow into MSB) XOR b_out.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear.
  - out_valid = 0, diff = 0, b_out = 0, ovf = 0.
  - in_ready = 1 once rst_n is high.
  - Reset mid-operation discards all in-flight results; none emerge after release.
- Slice k covers bits [4k+3:4k] and implements borrow lookahead:
  - g_i = ~a_i & b_i, p_i = ~(a_i ^ b_i).
  - br_{i+1} = g_i | (p_i & br_i), expanded flat across all 4 bits (no ripple inside a slice).
  - d_i = a_i ^ b_i ^ br_i.
- Pipeline:
  - On accept (in_valid & in_ready), slice 0 is computed from inputs and b_in.
  - Stage 0 register captures: diff[3:0], the borrow out of slice 0, the unconsumed upper bits of a and b, and valid = 1.
  - Stage k register captures slice k's result using the borrow from stage k-1, passing lower diff bits through.
  - Outputs are driven directly from stage STAGES-1 registers.
- Latency: exactly STAGES cycles from the accept edge to out_valid = 1 with no stall (4 for WIDTH = 16).
- Throughput: one result per cycle while out_ready = 1.
- Stall: stall = out_valid & ~out_ready.
  - While stall = 1, every stage register holds and in_ready = 0.
  - in_ready = ~stall (combinational from out_ready; no combinational path from in_valid).
- Bubbles: empty stages shift forward with valid = 0.
  - diff, b_out and ovf hold their last values while out_valid = 0.
- Handshake rules:
  - A result leaves on a cycle with out_valid & out_ready.
  - Results leave in strict acceptance order; none are dropped or duplicated.
  - Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- Arithmetic:
  - Wrap-around is modulo 2^WIDTH, e.g. 0 - 1 gives all-ones with b_out = 1.
  - ovf uses the borrow into bit WIDTH-1 and b_out of that same operation.
  - a = b with b_in = 0 gives diff = 0, b_out = 0, ovf = 0.
- Output stability: while out_valid = 1 and out_ready = 0, diff, b_out and ovf must not change.
- Input handling: inputs are ignored while in_ready = 0, even with in_valid = 1.

Test Plan:
- Reset, then a=4, b=5, b_in=1, out_ready=1 -> 4 cycles later out_valid=1, diff=0xFFFE, b_out=1, ovf=0.
- a=4, b=3, b_in=0 on the next cycle -> the following cycle gives diff=0x0001, b_out=0, ovf=0; the two results arrive back-to-back in order.
- a=0x8000, b=0x0001, b_in=0 -> diff=0x7FFF, b_out=0, ovf=1. a=0x0000, b=0x0000, b_in=1 -> diff=0xFFFF, b_out=1, ovf=0.
- Stream 10 random pairs with in_valid=1, and hold out_ready=0 for cycles 6-9 -> in_ready drops for exactly those cycles, outputs stay frozen, and all 10 results match a reference model in order with no loss.
- Accept 3 operand sets, then pulse rst_n low for 1 cycle between clock edges -> out_valid=0 immediately; after release no result appears and in_ready=1.
- Borrow across all slices: a=0x1000, b=0x0001, b_in=0 -> diff=0x0FFF, b_out=0, ovf=0 (borrow chain passes through 3 stages).
